// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | muldiv_ctrl : one-bit-per-cycle MULT/MULTU/DIV/DIVU sequencer, HI/LO   |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             hilo_rd,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dbz
);

  localparam int c_cnt_w = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_count;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_addend;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  logic               w_is_div;
  logic               w_neg1;
  logic               w_neg2;
  logic               w_div0;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;

  assign w_is_div = op[1];
  assign w_neg1   = op[0] & operand1[WIDTH-1];
  assign w_neg2   = op[0] & operand2[WIDTH-1];
  assign w_div0   = w_is_div & (operand2 == {WIDTH{1'b0}});
  assign w_abs1   = w_neg1 ? ({WIDTH{1'b0}} - operand1) : operand1;
  assign w_abs2   = w_neg2 ? ({WIDTH{1'b0}} - operand2) : operand2;

  // Shared adder: multiply adds into {carry, P_hi}; divide trial-subtracts from the shifted {R, Q[msb]}.
  logic [WIDTH:0]     w_a;
  logic [WIDTH:0]     w_b;
  logic [WIDTH+1:0]   w_sum;
  logic               w_fit;
  logic [WIDTH:0]     w_mul_next;
  logic [WIDTH-1:0]   w_run_hi;
  logic [WIDTH-1:0]   w_run_lo;

  assign w_a        = r_is_div ? {r_acc_hi, r_acc_lo[WIDTH-1]} : {1'b0, r_acc_hi};
  assign w_b        = {1'b0, r_addend};
  assign w_sum      = r_is_div ? ({1'b0, w_a} - {1'b0, w_b}) : ({1'b0, w_a} + {1'b0, w_b});
  assign w_fit      = ~w_sum[WIDTH+1];
  assign w_mul_next = r_acc_lo[0] ? w_sum[WIDTH:0] : w_a;

  always_comb begin
    if (r_is_div) begin
      w_run_hi = w_fit ? w_sum[WIDTH-1:0] : w_a[WIDTH-1:0];
      w_run_lo = {r_acc_lo[WIDTH-2:0], w_fit};
    end else begin
      w_run_hi = w_mul_next[WIDTH:1];
      w_run_lo = {w_mul_next[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] w_prod_neg;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_prod_neg = {(2*WIDTH){1'b0}} - {r_acc_hi, r_acc_lo};

  always_comb begin
    if (r_is_div) begin
      w_fix_hi = r_neg_rem ? ({WIDTH{1'b0}} - r_acc_hi) : r_acc_hi;
      w_fix_lo = r_neg_res ? ({WIDTH{1'b0}} - r_acc_lo) : r_acc_lo;
    end else begin
      w_fix_hi = r_neg_res ? w_prod_neg[2*WIDTH-1:WIDTH] : r_acc_hi;
      w_fix_lo = r_neg_res ? w_prod_neg[WIDTH-1:0]       : r_acc_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_addend  <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_div <= w_is_div;
            r_count  <= '0;
            r_dbz    <= w_div0;
            if (w_div0) begin
              // Divide by zero skips the iterations and commits these raw values.
              r_acc_hi  <= operand1;
              r_acc_lo  <= '1;
              r_neg_res <= 1'b0;
              r_neg_rem <= 1'b0;
              r_state   <= S_FIX;
            end else begin
              r_addend  <= w_is_div ? w_abs2 : w_abs1;
              r_acc_lo  <= w_is_div ? w_abs1 : w_abs2;
              r_acc_hi  <= '0;
              r_neg_res <= w_neg1 ^ w_neg2;
              r_neg_rem <= w_is_div & w_neg1;
              r_state   <= S_RUN;
            end
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_acc_hi <= w_run_hi;
          r_acc_lo <= w_run_lo;
          r_count  <= r_count + c_cnt_w'(1);
          if (r_count == {c_cnt_w{1'b1}}) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign busy  = (r_state != S_IDLE);
  assign stall = busy & (start | hilo_rd | hi_we | lo_we);
  assign done  = r_done;
  assign dbz   = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// tb_muldiv_ctrl : directed and randomized checks of muldiv_ctrl against a
// latency-countdown model that computes results with plain 64-bit arithmetic.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        hilo_rd;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  logic        dbz;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand1(operand1), .operand2(operand2), .hilo_rd(hilo_rd),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done), .dbz(dbz)
  );

  // Model: architectural HI/LO, pending result and cycles left until commit.
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  logic        m_done, m_dbz;
  int          m_left = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_res_hi = '0; m_res_lo = '0;
    m_done = 1'b0; m_dbz = 1'b0; m_left = 0;
  endtask

  task automatic model_edge();
    logic [63:0] p;
    longint      sa, sb, q, r;
    if (m_left != 0) begin
      m_left--;
      m_done = (m_left == 0);
      if (m_left == 0) begin
        m_hi = m_res_hi;
        m_lo = m_res_lo;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        sa     = longint'($signed(operand1));
        sb     = longint'($signed(operand2));
        m_dbz  = op[1] && (operand2 == 32'h0);
        m_left = m_dbz ? 1 : 33;
        if (m_dbz) p = {operand1, 32'hFFFFFFFF};
        else begin
          case (op)
            2'b00: p = {32'h0, operand1} * {32'h0, operand2};
            2'b01: p = sa * sb;
            2'b10: p = {operand1 % operand2, operand1 / operand2};
            default: begin
              q = sa / sb;
              r = sa % sb;
              p = {r[31:0], q[31:0]};
            end
          endcase
        end
        m_res_hi = p[63:32];
        m_res_lo = p[31:0];
      end else begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    chk("busy",  32'(busy),  32'(m_left != 0));
    chk("stall", 32'(stall), 32'((m_left != 0) && (start || hilo_rd || hi_we || lo_we)));
    chk("done",  32'(done),  32'(m_done));
    chk("dbz",   32'(dbz),   32'(m_dbz));
    chk("hi",    hi,         m_hi);
    chk("lo",    lo,         m_lo);
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; operand1 = a; operand2 = b;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic [31:0] eh,
                           input logic [31:0] el, input logic ed);
    int n;
    step();
    n = 1;
    start = 1'b0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(exp_lat));
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    chk({name, " dbz"}, 32'(dbz), 32'(ed));
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] eh,
                        input logic [31:0] el, input logic ed);
    issue(o, a, b);
    wait_done(name, lat, eh, el, ed);
  endtask

  task automatic count_stall(output int n);
    n = 0;
    #1;
    while (stall && n < 100) begin
      n++;
      step();
      #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; operand1 = '0; operand2 = '0;
    hilo_rd = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    model_reset();
    repeat (3) step();
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset dbz", 32'(dbz), 32'h0);
    rst_n = 1'b1;

    hi_we = 1'b1; wdata = 32'h5A5A0001; step(); hi_we = 1'b0;
    chk("mthi idle", hi, 32'h5A5A0001);

    run_op("multu max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult -3x5", 2'b01, 32'hFFFFFFFD, 32'd5, 34, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("mult minxmin", 2'b01, 32'h80000000, 32'h80000000, 34, 32'h40000000, 32'h0, 1'b0);
    run_op("divu 100/7", 2'b10, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
    run_op("div -7/2", 2'b11, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div 7/-2", 2'b11, 32'd7, 32'hFFFFFFFE, 34, 32'd1, 32'hFFFFFFFD, 1'b0);
    run_op("div by zero", 2'b11, 32'h1234, 32'h0, 2, 32'h1234, 32'hFFFFFFFF, 1'b1);
    run_op("multu clears dbz", 2'b00, 32'd2, 32'd3, 34, 32'h0, 32'd6, 1'b0);

    // MFHI/MFLO right behind a multiply
    issue(2'b00, 32'hFFFFFFFF, 32'd2); step(); start = 1'b0; hilo_rd = 1'b1;
    count_stall(n);
    chk("mfhi stall cycles", 32'(n), 32'd33);
    chk("mfhi new hi", hi, 32'h1);
    chk("mfhi new lo", lo, 32'hFFFFFFFE);
    hilo_rd = 1'b0;

    // Second start held against a divide in flight
    issue(2'b10, 32'd100, 32'd7); step();
    operand1 = 32'hFFFFFFF9; operand2 = 32'd2; op = 2'b11;
    count_stall(n);
    chk("2nd start stall cycles", 32'(n), 32'd33);
    chk("1st divu lo", lo, 32'd14);
    wait_done("2nd start div", 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

    // MTLO held while busy
    issue(2'b00, 32'd3, 32'd4); step(); start = 1'b0;
    lo_we = 1'b1; wdata = 32'hABCD;
    count_stall(n);
    chk("mtlo stall cycles", 32'(n), 32'd33);
    chk("lo before mtlo", lo, 32'd12);
    step(); lo_we = 1'b0;
    chk("mtlo written", lo, 32'hABCD);
    chk("hi after mtlo", hi, 32'h0);

    // Reset mid-operation
    issue(2'b01, 32'hFFFFFFF9, 32'd6); step(); start = 1'b0;
    repeat (10) step();
    #1 rst_n = 1'b0; model_reset();
    #1;
    chk("midrst hi", hi, 32'h0);
    chk("midrst lo", lo, 32'h0);
    chk("midrst busy", 32'(busy), 32'h0);
    chk("midrst done", 32'(done), 32'h0);
    step(); step(); rst_n = 1'b1;
    run_op("multu 3x4 after reset", 2'b00, 32'd3, 32'd4, 34, 32'h0, 32'd12, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
      hi_we = 1'($urandom_range(0, 1)); lo_we = 1'($urandom_range(0, 1)); wdata = $urandom;
      step();
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
        hilo_rd = ($urandom_range(0, 3) == 0);
        hi_we   = ($urandom_range(0, 4) == 0);
        lo_we   = ($urandom_range(0, 4) == 0);
        wdata   = $urandom;
        step();
        if (m_left == 0) break;
      end
      if ($urandom_range(0, 2) == 0) begin
        hi_we = 1'b0; lo_we = 1'b1; wdata = $urandom;
        step();
      end
      hilo_rd = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer with HI/LO register file for the EX stage. Accepts MULT/MULTU/DIV/DIVU from EX, iterates one bit per cycle on a shared 32-bit add/subtract path, and commits a 64-bit result to HI/LO. It drives a stall to the pipeline control only when a later instruction touches HI/LO, or issues another mul/div, while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  EX holds a mul/div instruction this cycle.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- operand1  in  32  multiplicand / dividend (rs).
- operand2  in  32  multiplier / divisor (rt).
- hilo_rd  in  1  EX holds MFHI or MFLO.
- hi_we  in  1  MTHI.
- lo_we  in  1  MTLO.
- wdata  in  32  MTHI/MTLO data.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  state != IDLE.
- stall  out  1  busy & (start | hilo_rd | hi_we | lo_we); combinational.
- done  out  1  one-cycle registered pulse after a commit.
- dbz  out  1  last DIV/DIVU had operand2 == 0; registered.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Latch op.
  - For signed ops, latch |operand1| and |operand2|, plus sign flags. |0x80000000| = 0x80000000 treated as unsigned.
  - Clear the 5-bit count and go to RUN.
- IDLE, start=1 with a divide and operand2 == 0:
  - Preload lo = 0xFFFFFFFF and hi = operand1 (raw).
  - Set dbz and go directly to FIX.
- RUN, multiply: shift-add on a 65-bit accumulator {carry, P_hi, P_lo}. P_lo starts as the multiplier and P_hi as 0. Add the multiplicand to P_hi when P_lo[0]=1, then shift right 1.
- RUN, divide: restoring division on {R, Q}. Shift left 1, trial-subtract the divisor from R, keep the result if it is non-negative, and set Q[0].
- RUN exits to FIX when count == 31, i.e. after 32 iterations.
- FIX, sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; negate the remainder if the dividend is negative.
  - Divide: hi = remainder, lo = quotient.
  - Commit hi/lo, pulse done, go to IDLE.
  - dbz path: commit the preloaded values unchanged.
- dbz updates on every accepted divide start and clears on an accepted multiply start.
- MTHI/MTLO in IDLE: write wdata to hi/lo at the edge. In IDLE, start has priority and a same-cycle write is dropped.
- While busy:
  - start, hi_we and lo_we are ignored, and stall is asserted.
  - The requester holds its inputs until stall falls; the request is then accepted in IDLE.
- hilo_rd in IDLE: no stall; hi/lo reflect all prior commits and writes.

## Timing
- Reset (async, any state) forces:
  - state = IDLE, hi = lo = 0, done = 0, dbz = 0, busy = 0, stall = 0.
  - Any in-flight operation is abandoned without commit.
- Normal op: start sampled at edge E0.
  - busy = 1 after E0.
  - RUN iterations occur at edges E1..E32; FIX is entered after E32.
  - Commit at E33: busy = 0 and done = 1 for the cycle after E33.
  - Next start is accepted at E34 at the earliest. Results are readable by MFHI/MFLO in the cycle after E33.
- Divide by zero: start sampled at E0, FIX after E0, commit at E1, done for the cycle after E1.
- stall is combinational from busy and the request inputs, so a request arriving in the commit cycle is still stalled. It is accepted at the first edge with state == IDLE.
- done is never asserted with busy = 1.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001; done exactly 34 cycles after start is sampled; busy high in between.
- MULT 0xFFFFFFFD (−3) × 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> hi = 0x40000000, lo = 0.
- DIVU 100 / 7 -> lo = 14, hi = 2. DIV −7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV 7 / −2 -> lo = 0xFFFFFFFD, hi = 1.
- DIV 0x1234 / 0 -> lo = 0xFFFFFFFF, hi = 0x1234, dbz = 1, done 2 cycles after start. A following MULTU clears dbz.
- Hazards:
  - hilo_rd asserted the cycle after start -> stall high until the commit cycle inclusive; the MFHI after that sees the new hi.
  - A second start mid-operation is stalled, then accepted at E34.
  - MTLO 0xABCD while busy is dropped until the stall falls, then written.
- Reset asserted at iteration 10 of a MULT -> all outputs 0 immediately. After release, a fresh MULTU 3 × 4 gives lo = 12, hi = 0 with normal latency.
